tmr_writeback_voter: RTL

- Majority voter that sits directly upstream of the lockstep/rollback controller.
- Collects the writeback (retire) tuple from each of the three redundant RISC-V cores and tolerates bounded retire skew between them.
- Votes on the collected tuples and produces the 3-bit agreement vector Voter_state (111 = full match, 000 = no majority) plus the majority-voted PC/result.
- Tracks per-core consecutive-mismatch counts and raises a sticky fault flag for persistently bad cores.

---
 rtl/tmr_writeback_voter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/tmr_writeback_voter.sv
// rtl/tmr_writeback_voter.sv - triple-core writeback collector and majority voter
module tmr_writeback_voter #(
    parameter int XLEN         = 32,
    parameter int SKEW_MAX     = 4,
    parameter int CNT_W        = 4,
    parameter int FAULT_THRESH = 3
) (
    input  logic            clk,
    input  logic            rst_in,
    input  logic [2:0]      wb_valid,
    input  logic [XLEN-1:0] wb_pc_a,
    input  logic [XLEN-1:0] wb_pc_b,
    input  logic [XLEN-1:0] wb_pc_c,
    input  logic [XLEN-1:0] wb_data_a,
    input  logic [XLEN-1:0] wb_data_b,
    input  logic [XLEN-1:0] wb_data_c,
    input  logic [4:0]      wb_rd_a,
    input  logic [4:0]      wb_rd_b,
    input  logic [4:0]      wb_rd_c,
    input  logic            wb_we_a,
    input  logic            wb_we_b,
    input  logic            wb_we_c,
    input  logic            core_hold,
    output logic [2:0]      core_stall,
    output logic [2:0]      Voter_state,
    output logic            voted_valid,
    output logic [XLEN-1:0] voted_pc,
    output logic [XLEN-1:0] voted_data,
    output logic [4:0]      voted_rd,
    output logic            voted_we,
    output logic [CNT_W-1:0] fault_count_a,
    output logic [CNT_W-1:0] fault_count_b,
    output logic [CNT_W-1:0] fault_count_c,
    output logic [2:0]      core_faulty,
    output logic            timeout
);

    localparam int SKW = (SKEW_MAX > 1) ? $clog2(SKEW_MAX) : 1;
    localparam logic [SKW-1:0]   SKEW_LAST = SKW'(SKEW_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_THR   = CNT_W'(FAULT_THRESH);

    typedef enum logic [1:0] {IDLE, COLLECT, VOTE} state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
        logic [4:0]      rd;
        logic            we;
    } tuple_t;

    // Index 2 = core A, 1 = B, 0 = C, matching the wb_valid bit order
    state_t          state, state_d;
    logic [SKW-1:0]  skew_cnt, skew_d;
    logic            timeout_pending, tp_d;
    tuple_t          slot [3];
    tuple_t          in_tup [3];
    logic [2:0]      slot_full;
    logic [2:0]      cap;
    logic [2:0]      full_next;
    logic            vote_exit;
    logic [2:0]      agree;
    logic            eq_ab, eq_ac, eq_bc;
    tuple_t          winner;
    logic [CNT_W-1:0] cnt [3];
    logic [CNT_W-1:0] cnt_d [3];

    // Empty slots never compare equal; rd/data only matter for real register writes
    function automatic logic tuple_eq(input tuple_t x, input tuple_t y,
                                      input logic fx, input logic fy);
        return fx && fy && (x.pc == y.pc) && (x.we == y.we) &&
               (!x.we || ((x.rd == y.rd) && (x.data == y.data)));
    endfunction

    assign core_stall = slot_full | {3{state == VOTE}} | {3{core_hold}};
    assign cap        = wb_valid & ~core_stall;
    assign full_next  = slot_full | cap;
    assign vote_exit  = (state == VOTE) && !core_hold;

    assign fault_count_a = cnt[2];
    assign fault_count_b = cnt[1];
    assign fault_count_c = cnt[0];

    // Gather the per-core retire tuples into indexable form
    always_comb begin
        in_tup[2] = '{pc: wb_pc_a, data: wb_data_a, rd: wb_rd_a, we: wb_we_a};
        in_tup[1] = '{pc: wb_pc_b, data: wb_data_b, rd: wb_rd_b, we: wb_we_b};
        in_tup[0] = '{pc: wb_pc_c, data: wb_data_c, rd: wb_rd_c, we: wb_we_c};
    end

    // Collection FSM next state; core_hold freezes every state including VOTE
    always_comb begin
        state_d = state;
        skew_d  = skew_cnt;
        tp_d    = timeout_pending;
        if (!core_hold) begin
            case (state)
                IDLE: begin
                    if (|cap) begin
                        state_d = (full_next == 3'b111) ? VOTE : COLLECT;
                        skew_d  = '0;
                    end
                end
                COLLECT: begin
                    if (full_next == 3'b111) begin
                        state_d = VOTE;
                    end else if (skew_cnt == SKEW_LAST) begin
                        state_d = VOTE;
                        tp_d    = 1'b1;
                    end else begin
                        skew_d = skew_cnt + 1'b1;
                    end
                end
                VOTE: begin
                    state_d = IDLE;
                    tp_d    = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state, skew counter and forced-vote marker
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state           <= IDLE;
            skew_cnt        <= '0;
            timeout_pending <= 1'b0;
        end else begin
            state           <= state_d;
            skew_cnt        <= skew_d;
            timeout_pending <= tp_d;
        end
    end

    // Capture slots; emptied once the vote has been taken
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            slot_full <= '0;
            for (int i = 0; i < 3; i++) slot[i] <= '0;
        end else if (vote_exit) begin
            slot_full <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (cap[i]) begin
                    slot[i]      <= in_tup[i];
                    slot_full[i] <= 1'b1;
                end
            end
        end
    end

    // Pairwise comparison, agreement vector and priority pick of the voted tuple
    always_comb begin
        eq_ab    = tuple_eq(slot[2], slot[1], slot_full[2], slot_full[1]);
        eq_ac    = tuple_eq(slot[2], slot[0], slot_full[2], slot_full[0]);
        eq_bc    = tuple_eq(slot[1], slot[0], slot_full[1], slot_full[0]);
        agree[2] = eq_ab | eq_ac;
        agree[1] = eq_ab | eq_bc;
        agree[0] = eq_ac | eq_bc;
        if (agree[2])      winner = slot[2];
        else if (agree[1]) winner = slot[1];
        else               winner = slot[0];
    end

    // Consecutive-mismatch counters: clear on agreement, saturate otherwise
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt[i];
            if (agree[i])              cnt_d[i] = '0;
            else if (cnt[i] != CNT_MAX) cnt_d[i] = cnt[i] + 1'b1;
        end
    end

    // Registered vote results, pulses, counters and sticky fault flags
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            Voter_state <= 3'b111;
            voted_valid <= 1'b0;
            voted_pc    <= '0;
            voted_data  <= '0;
            voted_rd    <= '0;
            voted_we    <= 1'b0;
            timeout     <= 1'b0;
            core_faulty <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            voted_valid <= 1'b0;
            timeout     <= 1'b0;
            if (vote_exit) begin
                Voter_state <= agree;
                timeout     <= timeout_pending;
                if (|agree) begin
                    voted_valid <= 1'b1;
                    voted_pc    <= winner.pc;
                    voted_data  <= winner.data;
                    voted_rd    <= winner.rd;
                    voted_we    <= winner.we;
                end
                for (int i = 0; i < 3; i++) begin
                    cnt[i] <= cnt_d[i];
                    if (cnt_d[i] >= CNT_THR) core_faulty[i] <= 1'b1;
                end
            end
        end
    end

endmodule
